upc_sequencer: RTL and testbench

Micro-program sequencer for the CtrlPIM control unit. It accepts macro-instructions from the host instruction queue and walks their micro-routines in the control store. It generates the micro-PC (uPC) and evaluates each micro-word's next-address field: sequential, jump, conditional branch on the `eqz` flag result, call/return, PIM wait, and end. It sits between the instruction queue and the control-store/decoding stage, and it stalls on the PIM array's busy signal.

---
 rtl/ctrlpim_pkg.sv | 27 ++
 rtl/upc_ras.sv | 51 +++++
 rtl/upc_sequencer.sv | 169 ++++++++++++++++
 tb/tb_upc_sequencer.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrlpim_pkg.sv
// Shared types for the CtrlPIM control unit: sequencer op codes and state encoding.
// No logic; imported by the micro-program sequencer and its return-address stack.
// UPC_AW is the default control-store address width.
package ctrlpim_pkg;

  localparam int unsigned UPC_AW = 8;

  // Next-address op carried in every micro-word.
  typedef enum logic [2:0] {
    OP_NEXT = 3'd0,
    OP_JMP  = 3'd1,
    OP_BRZ  = 3'd2,
    OP_BRNZ = 3'd3,
    OP_CALL = 3'd4,
    OP_RET  = 3'd5,
    OP_WAIT = 3'd6,
    OP_END  = 3'd7
  } seq_op_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_ERR   = 2'd3
  } seq_state_t;

endpackage

// File: rtl/upc_ras.sv
// Return-address LIFO: push/pop/clear, top-of-stack and occupancy outputs.
// Latency: push/pop take effect on the next edge; top is combinational from storage.
// Backpressure: none; the caller must not push when full or pop when empty (ignored).
module upc_ras #(
  parameter  int unsigned AW    = 8,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned SPW   = $clog2(DEPTH) + 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clear,
  input  logic           push,
  input  logic           pop,
  input  logic [AW-1:0]  push_dat,
  output logic [AW-1:0]  top,
  output logic           full,
  output logic           empty,
  output logic [SPW-1:0] count
);

  logic [AW-1:0]  mem_q [DEPTH];
  logic [SPW-1:0] cnt_q;
  logic [SPW-2:0] wr_idx;
  logic [SPW-2:0] rd_idx;

  // Write slot is the current occupancy; top of stack sits one below it.
  assign wr_idx = cnt_q[SPW-2:0];
  assign rd_idx = wr_idx - (SPW-1)'(1);
  assign top    = mem_q[rd_idx];
  assign full   = (cnt_q == SPW'(DEPTH));
  assign empty  = (cnt_q == '0);
  assign count  = cnt_q;

  // Stack storage and occupancy; clear wins over push/pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (clear) begin
      cnt_q <= '0;
    end else if (push && !full) begin
      mem_q[wr_idx] <= push_dat;
      cnt_q         <= cnt_q + SPW'(1);
    end else if (pop && !empty) begin
      cnt_q <= cnt_q - SPW'(1);
    end
  end

endmodule

// File: rtl/upc_sequencer.sv
// Micro-program sequencer: accepts macro-instructions and walks their micro-routines (uPC + next-address eval).
// Latency: 2 cycles per micro-word (FETCH, EXEC), +1 per busy cycle on WAIT; first cs_rd one cycle after accept.
// Backpressure: instr_ready only in IDLE; stalls in EXEC on WAIT while pim_busy. UPC_RAS_EN selects full stack vs link register.
module upc_sequencer
  import ctrlpim_pkg::*;
#(
  parameter  int unsigned AW        = UPC_AW,
  parameter  int unsigned RAS_DEPTH = 4,
  localparam int unsigned SPW       = $clog2(RAS_DEPTH) + 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           instr_valid,
  input  logic [AW-1:0]  instr_entry,
  output logic           instr_ready,
  output logic [AW-1:0]  upc,
  output logic           cs_rd,
  input  logic [2:0]     seq_op,
  input  logic [AW-1:0]  br_target,
  input  logic           eqz,
  input  logic           pim_busy,
  input  logic           err_clr,
  output logic           done,
  output logic           err,
  output logic [SPW-1:0] sp
);

  seq_state_t    state_q, state_d;
  logic [AW-1:0] upc_q, upc_d;
  logic [AW-1:0] upc_inc;
  logic          cs_rd_q, done_q, done_d, err_q;
  seq_op_t       op;

  logic          st_push, st_pop, st_clear;
  logic          st_full, st_empty;
  logic [AW-1:0] st_top;

  assign op      = seq_op_t'(seq_op);
  assign upc_inc = upc_q + AW'(1);

  // Next-state and next-uPC selection; stack strobes are decoded here too.
  always_comb begin
    state_d  = state_q;
    upc_d    = upc_q;
    done_d   = 1'b0;
    st_push  = 1'b0;
    st_pop   = 1'b0;
    st_clear = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (instr_valid) begin
          upc_d    = instr_entry;
          st_clear = 1'b1;
          state_d  = ST_FETCH;
        end
      end
      ST_FETCH: state_d = ST_EXEC;
      ST_EXEC: begin
        state_d = ST_FETCH;
        case (op)
          OP_NEXT: upc_d = upc_inc;
          OP_JMP:  upc_d = br_target;
          OP_BRZ:  upc_d = eqz ? br_target : upc_inc;
          OP_BRNZ: upc_d = eqz ? upc_inc : br_target;
          OP_CALL: begin
            if (st_full) begin
              state_d = ST_ERR;
            end else begin
              st_push = 1'b1;
              upc_d   = br_target;
            end
          end
          OP_RET: begin
            if (st_empty) begin
              state_d = ST_ERR;
            end else begin
              st_pop = 1'b1;
              upc_d  = st_top;
            end
          end
          OP_WAIT: begin
            if (pim_busy) begin
              state_d = ST_EXEC;
            end else begin
              upc_d = upc_inc;
            end
          end
          OP_END: begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
          default: state_d = ST_FETCH;
        endcase
      end
      ST_ERR: begin
        if (err_clr) begin
          st_clear = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, uPC and registered strobes; cs_rd/err mirror the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      upc_q   <= '0;
      cs_rd_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      upc_q   <= upc_d;
      cs_rd_q <= (state_d == ST_FETCH);
      done_q  <= done_d;
      err_q   <= (state_d == ST_ERR);
    end
  end

`ifdef UPC_RAS_EN
  upc_ras #(
    .AW    (AW),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (st_clear),
    .push     (st_push),
    .pop      (st_pop),
    .push_dat (upc_inc),
    .top      (st_top),
    .full     (st_full),
    .empty    (st_empty),
    .count    (sp)
  );
`else
  logic [AW-1:0] link_q;
  logic          link_vld_q;

  // Single link register: one level of call, valid flag doubles as occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      link_q     <= '0;
      link_vld_q <= 1'b0;
    end else if (st_clear) begin
      link_vld_q <= 1'b0;
    end else if (st_push) begin
      link_q     <= upc_inc;
      link_vld_q <= 1'b1;
    end else if (st_pop) begin
      link_vld_q <= 1'b0;
    end
  end

  assign st_top   = link_q;
  assign st_full  = link_vld_q;
  assign st_empty = !link_vld_q;
  assign sp       = SPW'(link_vld_q);
`endif

  assign instr_ready = (state_q == ST_IDLE);
  assign upc         = upc_q;
  assign cs_rd       = cs_rd_q;
  assign done        = done_q;
  assign err         = err_q;

endmodule

// File: tb/tb_upc_sequencer.sv
module tb_upc_sequencer;

  localparam logic [2:0] NEXT = 3'd0, JMP = 3'd1, BRZ = 3'd2, BRNZ = 3'd3;
  localparam logic [2:0] CALL = 3'd4, RET = 3'd5, WAIT = 3'd6, ENDW = 3'd7;

  logic       clk;
  logic       rst_n;
  logic       instr_valid;
  logic [7:0] instr_entry;
  logic       instr_ready;
  logic [7:0] upc;
  logic       cs_rd;
  logic [2:0] seq_op;
  logic [7:0] br_target;
  logic       eqz;
  logic       pim_busy;
  logic       err_clr;
  logic       done;
  logic       err;
  logic [2:0] sp;

  int checks = 0;
  int errors = 0;

  upc_sequencer #(.AW(8), .RAS_DEPTH(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr_entry (instr_entry),
    .instr_ready (instr_ready),
    .upc         (upc),
    .cs_rd       (cs_rd),
    .seq_op      (seq_op),
    .br_target   (br_target),
    .eqz         (eqz),
    .pim_busy    (pim_busy),
    .err_clr     (err_clr),
    .done        (done),
    .err         (err),
    .sp          (sp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Control-store model: micro-words indexed by address.
  typedef struct {
    logic [2:0] op;
    logic [7:0] tgt;
    logic       z;
    int         busy;
  } word_t;
  word_t cs_mem [256];

  // Expected output events: a fetch (upc, sp) or a done pulse.
  typedef struct {
    bit         is_done;
    logic [7:0] upc;
    logic [2:0] sp;
  } evt_t;
  evt_t exp_q[$];

  task automatic put(input logic [7:0] a, input logic [2:0] op, input logic [7:0] tgt,
                     input logic z, input int busy);
    cs_mem[a].op   = op;
    cs_mem[a].tgt  = tgt;
    cs_mem[a].z    = z;
    cs_mem[a].busy = busy;
  endtask

  task automatic exp_fetch(input logic [7:0] a, input logic [2:0] s);
    evt_t e;
    e.is_done = 1'b0;
    e.upc     = a;
    e.sp      = s;
    exp_q.push_back(e);
  endtask

  task automatic exp_done();
    evt_t e;
    e.is_done = 1'b1;
    e.upc     = '0;
    e.sp      = '0;
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Control-store read port: data for the fetched word appears in EXEC; WAIT busy pattern follows.
  initial begin
    int rem;
    word_t w;
    rem       = 0;
    seq_op    = NEXT;
    br_target = '0;
    eqz       = 1'b0;
    pim_busy  = 1'b0;
    forever begin
      @(negedge clk);
      if (cs_rd) begin
        w         = cs_mem[upc];
        seq_op    = w.op;
        br_target = w.tgt;
        eqz       = w.z;
        rem       = w.busy;
        pim_busy  = 1'b0;
      end else begin
        pim_busy = (rem > 0);
        if (rem > 0) rem--;
      end
    end
  end

  // Monitor: every fetch strobe or done pulse must match the next expected event.
  initial begin
    evt_t e;
    forever begin
      @(posedge clk);
      #1;
      if (cs_rd || done) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event: cs_rd=%0b done=%0b upc=0x%0h, expected no event", cs_rd, done, upc);
        end else begin
          e = exp_q.pop_front();
          if (e.is_done) begin
            if (!done) begin
              errors++;
              $display("FAIL event_kind: got fetch upc=0x%0h, expected done pulse", upc);
            end
          end else if (done || upc !== e.upc || sp !== e.sp) begin
            errors++;
            $display("FAIL fetch: got done=%0b upc=0x%0h sp=%0d, expected fetch upc=0x%0h sp=%0d",
                     done, upc, sp, e.upc, e.sp);
          end
        end
      end
    end
  end

  task automatic accept(input logic [7:0] entry);
    @(negedge clk);
    check("ready_before_accept", {31'd0, instr_ready}, 32'd1);
    instr_valid = 1'b1;
    instr_entry = entry;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
  endtask

  // Runs until done or err; cyc is the cycle index (accept cycle + 1 = 1) where it was seen.
  task automatic run(output int cyc);
    cyc = 1;
    while (cyc < 300) begin
      @(posedge clk);
      #1;
      cyc++;
      if (done || err) break;
    end
    if (cyc >= 300) begin
      checks++;
      errors++;
      $display("FAIL run_timeout: got no done/err in %0d cycles, expected one", cyc);
    end
  endtask

  task automatic clear_err();
    repeat (3) @(negedge clk);
    check("err_sticky", {31'd0, err}, 32'd1);
    @(negedge clk);
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    check("err_cleared", {31'd0, err}, 32'd0);
    check("sp_after_clr", {29'd0, sp}, 32'd0);
    check("ready_after_clr", {31'd0, instr_ready}, 32'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    rst_n       = 1'b0;
    instr_valid = 1'b1;
    instr_entry = 8'h10;
    err_clr     = 1'b0;
    for (int i = 0; i < 256; i++) put(i[7:0], ENDW, 8'h00, 1'b0, 0);

    // Reset with instr_valid held
    repeat (3) @(negedge clk);
    check("rst_upc", {24'd0, upc}, 32'h0);
    check("rst_ready", {31'd0, instr_ready}, 32'd1);
    check("rst_cs_rd", {31'd0, cs_rd}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_sp", {29'd0, sp}, 32'd0);

    // NEXT, NEXT, END from 0x10; accepted on the first edge after release
    put(8'h10, NEXT, 8'h00, 1'b0, 0);
    put(8'h11, NEXT, 8'h00, 1'b0, 0);
    put(8'h12, ENDW, 8'h00, 1'b0, 0);
    exp_fetch(8'h10, 3'd0); exp_fetch(8'h11, 3'd0); exp_fetch(8'h12, 3'd0); exp_done();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    run(cyc);
    check("seq_done_cycle", cyc, 32'd7);
    check("seq_ready_after_end", {31'd0, instr_ready}, 32'd1);
    check("seq_upc_hold", {24'd0, upc}, 32'h12);

    // BRZ taken
    put(8'h20, BRZ, 8'h40, 1'b1, 0);
    put(8'h40, ENDW, 8'h00, 1'b0, 0);
    exp_fetch(8'h20, 3'd0); exp_fetch(8'h40, 3'd0); exp_done();
    accept(8'h20);
    run(cyc);
    check("brz_taken_cycle", cyc, 32'd5);

    // BRZ not taken, BRNZ taken, JMP to 0xFF, NEXT wraps to 0x00
    put(8'h20, BRZ, 8'h40, 1'b0, 0);
    put(8'h21, BRNZ, 8'h60, 1'b0, 0);
    put(8'h60, JMP, 8'hFF, 1'b1, 0);
    put(8'hFF, NEXT, 8'h00, 1'b0, 0);
    put(8'h00, ENDW, 8'h00, 1'b0, 0);
    exp_fetch(8'h20, 3'd0); exp_fetch(8'h21, 3'd0); exp_fetch(8'h60, 3'd0);
    exp_fetch(8'hFF, 3'd0); exp_fetch(8'h00, 3'd0); exp_done();
    accept(8'h20);
    run(cyc);
    check("wrap_done_cycle", cyc, 32'd11);
    check("wrap_no_err", {31'd0, err}, 32'd0);
    check("wrap_upc", {24'd0, upc}, 32'h00);

    // CALL 0x80 from 0x30, RET back to 0x31
    put(8'h30, CALL, 8'h80, 1'b0, 0);
    put(8'h80, RET, 8'h00, 1'b0, 0);
    put(8'h31, ENDW, 8'h00, 1'b0, 0);
    exp_fetch(8'h30, 3'd0); exp_fetch(8'h80, 3'd1); exp_fetch(8'h31, 3'd0); exp_done();
    accept(8'h30);
    run(cyc);
    check("callret_sp", {29'd0, sp}, 32'd0);

    // WAIT with pim_busy high for 3 EXEC cycles
    put(8'h05, WAIT, 8'h00, 1'b0, 3);
    put(8'h06, ENDW, 8'h00, 1'b0, 0);
    exp_fetch(8'h05, 3'd0); exp_fetch(8'h06, 3'd0); exp_done();
    accept(8'h05);
    run(cyc);
    check("wait_done_cycle", cyc, 32'd8);

`ifdef UPC_RAS_EN
    // Nested calls and returns
    put(8'hB0, CALL, 8'hC0, 1'b0, 0);
    put(8'hC0, CALL, 8'hD0, 1'b0, 0);
    put(8'hD0, RET, 8'h00, 1'b0, 0);
    put(8'hC1, RET, 8'h00, 1'b0, 0);
    put(8'hB1, ENDW, 8'h00, 1'b0, 0);
    exp_fetch(8'hB0, 3'd0); exp_fetch(8'hC0, 3'd1); exp_fetch(8'hD0, 3'd2);
    exp_fetch(8'hC1, 3'd1); exp_fetch(8'hB1, 3'd0); exp_done();
    accept(8'hB0);
    run(cyc);
    check("nested_no_err", {31'd0, err}, 32'd0);

    // Five nested CALLs overflow a 4-deep stack
    for (int i = 0; i < 5; i++) begin
      put(8'h90 + 8'(i), CALL, 8'h91 + 8'(i), 1'b0, 0);
      exp_fetch(8'h90 + 8'(i), 3'(i));
    end
    accept(8'h90);
    run(cyc);
    check("ovf_err", {31'd0, err}, 32'd1);
    check("ovf_sp", {29'd0, sp}, 32'd4);
    check("ovf_upc", {24'd0, upc}, 32'h94);
`else
    // Second CALL while the link is valid
    put(8'h90, CALL, 8'h91, 1'b0, 0);
    put(8'h91, CALL, 8'h92, 1'b0, 0);
    exp_fetch(8'h90, 3'd0); exp_fetch(8'h91, 3'd1);
    accept(8'h90);
    run(cyc);
    check("ovf_err", {31'd0, err}, 32'd1);
    check("ovf_sp", {29'd0, sp}, 32'd1);
    check("ovf_upc", {24'd0, upc}, 32'h91);
`endif
    check("ovf_ready", {31'd0, instr_ready}, 32'd0);
    check("ovf_cs_rd", {31'd0, cs_rd}, 32'd0);
    clear_err();

    // RET with nothing to return to
    put(8'hA0, RET, 8'h00, 1'b0, 0);
    exp_fetch(8'hA0, 3'd0);
    accept(8'hA0);
    run(cyc);
    check("unf_err", {31'd0, err}, 32'd1);
    check("unf_upc", {24'd0, upc}, 32'hA0);
    clear_err();

    // Reset in the middle of a long WAIT: no done must follow
    put(8'h05, WAIT, 8'h00, 1'b0, 20);
    exp_fetch(8'h05, 3'd0);
    accept(8'h05);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_upc", {24'd0, upc}, 32'h0);
    check("midrst_ready", {31'd0, instr_ready}, 32'd1);
    check("midrst_cs_rd", {31'd0, cs_rd}, 32'd0);
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    check("midrst_no_done", {31'd0, done}, 32'd0);

    check("exp_queue_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
